nios_mul_seq: RTL

- Multi-cycle 32x32 multiply sequencer for the Nios CPU multiply path.
- Time-shares one registered unsigned 16x16 multiplier cell: issues the 16-bit partial products in order, accumulates them, and returns the low or high 32 bits of the product.
- Sits between the execute stage (request/response handshake) and the multiplier cell (issue/enable interface).

---
 rtl/nios_mul_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/nios_mul_seq.sv
// nios_mul_seq: 32x32 multiply sequencer that time-shares one registered 16x16 multiplier cell.
// Define NIOS_MUL_HIGH_EN to add MULXUU/MULXSS/MULXSU; the default build executes every request as MUL.
module nios_mul_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [15:0] mc_a,
    output logic [15:0] mc_b,
    output logic        mc_en,
    input  logic [31:0] mc_p
);

`ifdef NIOS_MUL_HIGH_EN
    localparam int AccW = 64;
`else
    localparam int AccW = 32;
`endif

    typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [1:0]      k_q, k_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [AccW-1:0] accInit;
    logic [AccW-1:0] addend;
    logic [1:0]      prevIdx;
    logic [1:0]      lastK;
    logic            highOp;

`ifdef NIOS_MUL_HIGH_EN
    logic        high_q, high_d;
    logic [31:0] corr;

    // Signed high words are the unsigned high word plus this correction.
    always_comb begin
        corr = '0;
        if (req_op[1] && req_a[31]) begin
            corr = corr - req_b;
        end
        if (req_op == 2'b10 && req_b[31]) begin
            corr = corr - req_a;
        end
    end

    assign accInit = {corr, 32'h0};
    assign highOp  = high_q;
`else
    logic unused_op;

    assign unused_op = ^req_op;
    assign accInit   = '0;
    assign highOp    = 1'b0;
`endif

    assign lastK = highOp ? 2'd3 : 2'd2;

    // mc_p holds the product of the previous issue; weight it by that issue's half positions.
    always_comb begin
        prevIdx = k_q - 2'd1;
        addend  = AccW'({mc_p, 16'h0});
        if (prevIdx == 2'd0) begin
            addend = AccW'(mc_p);
        end
`ifdef NIOS_MUL_HIGH_EN
        else if (prevIdx == 2'd3) begin
            addend = {mc_p, 32'h0};
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
`ifdef NIOS_MUL_HIGH_EN
            high_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
`ifdef NIOS_MUL_HIGH_EN
            high_q  <= high_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        acc_d      = acc_q;
`ifdef NIOS_MUL_HIGH_EN
        high_d     = high_q;
`endif
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = '0;
        mc_en      = 1'b0;
        mc_a       = '0;
        mc_b       = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    k_d     = '0;
                    acc_d   = accInit;
`ifdef NIOS_MUL_HIGH_EN
                    high_d  = (req_op != 2'b00);
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // k[1] picks the a half, k[0] the b half: LL, LH, HL, HH.
                mc_en = 1'b1;
                mc_a  = k_q[1] ? a_q[31:16] : a_q[15:0];
                mc_b  = k_q[0] ? b_q[31:16] : b_q[15:0];
                if (k_q != 2'd0) begin
                    acc_d = acc_q + addend;
                end
                k_d = k_q + 2'd1;
                if (k_q == lastK) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                acc_d   = acc_q + addend;
                state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
`ifdef NIOS_MUL_HIGH_EN
                rsp_result = highOp ? acc_q[63:32] : acc_q[31:0];
`else
                rsp_result = acc_q[31:0];
`endif
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
